// File: rtl/expansion_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// expansion_pipe : edge-duplicating expand / checked compress, DEPTH-stage
//                  valid/ready register pipeline.            Rev 1.0
// ---------------------------------------------------------------------------
module expansion_pipe #(
    parameter int GROUPS  = 8,
    parameter int GROUP_W = 4,
    parameter int DEPTH   = 2,
    localparam int IN_W   = GROUPS * GROUP_W,
    localparam int OUT_W  = GROUPS * (GROUP_W + 2),
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             edge_error,
    output logic [OCC_W-1:0] occupancy
);

    localparam int CW = GROUP_W + 2;

    logic [OUT_W-1:0]  exp_w;
    logic [OUT_W-1:0]  cmp_w;
    logic [GROUPS-1:0] chunk_err_w;
    logic [OUT_W-1:0]  src_data_w;
    logic              src_err_w;

    for (genvar g = 0; g < GROUPS; g++) begin : g_chunk
        localparam int LEFT    = ((g + 1) * GROUP_W) % IN_W;
        localparam int RIGHT   = (g * GROUP_W + IN_W - 1) % IN_W;
        // Where the duplicated bits sit inside the middle fields of the expanded word
        localparam int LEFT_X  = (LEFT / GROUP_W) * CW + 1 + (LEFT % GROUP_W);
        localparam int RIGHT_X = (RIGHT / GROUP_W) * CW + 1 + (RIGHT % GROUP_W);

        assign exp_w[g*CW +: CW] = {data_in[LEFT], data_in[g*GROUP_W +: GROUP_W], data_in[RIGHT]};
        assign cmp_w[g*GROUP_W +: GROUP_W] = data_in[g*CW+1 +: GROUP_W];
        assign chunk_err_w[g] = (data_in[g*CW+CW-1] != data_in[LEFT_X])
                              | (data_in[g*CW] != data_in[RIGHT_X]);
    end

    assign cmp_w[OUT_W-1:IN_W] = '0;
    assign src_data_w = mode ? cmp_w : exp_w;
    assign src_err_w  = mode & (|chunk_err_w);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [OUT_W-1:0] data_q [DEPTH];
    logic [OUT_W-1:0] data_d [DEPTH];
    logic [DEPTH:0]   load_w;
    logic [DEPTH-1:0] src_v_w;
    logic [DEPTH-1:0] src_e_w;
    logic [OUT_W-1:0] src_d_w [DEPTH];

    always_comb begin
        src_v_w[0] = in_valid;
        src_d_w[0] = src_data_w;
        src_e_w[0] = src_err_w;
        for (int k = 1; k < DEPTH; k++) begin
            src_v_w[k] = valid_q[k-1];
            src_d_w[k] = data_q[k-1];
            src_e_w[k] = err_q[k-1];
        end

        // A stage can take new content if it is empty or everything downstream moves
        load_w[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            load_w[k] = ~valid_q[k] | load_w[k+1];
        end

        for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k];
            data_d[k]  = data_q[k];
            err_d[k]   = err_q[k];
            if (load_w[k]) begin
                valid_d[k] = src_v_w[k];
                if (src_v_w[k]) begin
                    data_d[k] = src_d_w[k];
                    err_d[k]  = src_e_w[k];
                end
            end
        end

        if (clear) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign in_ready   = ~clear & load_w[0];
    assign out_valid  = valid_q[DEPTH-1];
    assign data_out   = data_q[DEPTH-1];
    assign edge_error = err_q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expansion_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for expansion_pipe: expand/compress vectors, backpressure,
// clear, asynchronous reset, and an alternate-parameter instance.
module tb_expansion_pipe;

    localparam int PERIOD = 10;

    logic clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    logic        n_rst, clear, mode, in_valid, in_ready, out_valid, out_ready, edge_error;
    logic [47:0] data_in, data_out;
    logic [1:0]  occupancy;

    logic        a_clear, a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_edge_error;
    logic [15:0] a_data_in, a_data_out;
    logic [1:0]  a_occupancy;

    expansion_pipe dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .edge_error(edge_error), .occupancy(occupancy)
    );

    expansion_pipe #(.GROUPS(4), .GROUP_W(2), .DEPTH(3)) dut_alt (
        .clk(clk), .n_rst(n_rst), .clear(a_clear), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
        .edge_error(a_edge_error), .occupancy(a_occupancy)
    );

    typedef struct {
        logic        m;
        logic [47:0] d;
        logic [47:0] ed;
        logic        ee;
        bit          lat;
        time         t;
    } beat_t;

    beat_t stim_q[$];
    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    occ_model = 0;
    bit    front_seen = 1'b0;
    bit    saw_full = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [47:0] f_expand(input logic [31:0] x);
        logic [47:0] r;
        r = '0;
        for (int g = 0; g < 8; g++) begin
            r[g*6+5] = x[((g+1)*4) % 32];
            for (int b = 0; b < 4; b++) r[g*6+1+b] = x[g*4+b];
            r[g*6] = x[(g*4+31) % 32];
        end
        return r;
    endfunction

    // Monitor: compares the presented beat against the scoreboard head every cycle it is shown
    always @(negedge clk) begin
        if (n_rst === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 48'(out_valid), 48'd0);
            end else begin
                check("data_out", data_out, exp_q[0].ed);
                check("edge_error", 48'(edge_error), 48'(exp_q[0].ee));
                if (exp_q[0].lat && !front_seen)
                    check("latency", 48'($time - exp_q[0].t), 48'(2*PERIOD));
                front_seen = 1'b1;
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    front_seen = 1'b0;
                end
            end
        end
    end

    task automatic drive_head();
        if (stim_q.size() > 0) begin
            in_valid = 1'b1;
            mode     = stim_q[0].m;
            data_in  = stim_q[0].d;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic add(input logic m, input logic [47:0] d, input logic [47:0] ed,
                       input logic ee, input bit lat);
        beat_t b;
        b.m = m; b.d = d; b.ed = ed; b.ee = ee; b.lat = lat; b.t = 0;
        stim_q.push_back(b);
    endtask

    // One clock: checks and bookkeeping at the falling edge, drive after the rising edge
    task automatic cycle();
        int    nxt;
        beat_t b;
        @(negedge clk);
        nxt = occ_model;
        check("occupancy", 48'(occupancy), 48'(occ_model));
        check("in_ready", 48'(in_ready), 48'(!clear && (occ_model < 2 || out_ready)));
        if (!in_ready && !clear) saw_full = 1'b1;
        if (in_valid && in_ready) begin
            b = stim_q.pop_front();
            b.t = $time;
            exp_q.push_back(b);
            nxt++;
        end
        if (out_valid && out_ready) nxt--;
        if (clear) nxt = 0;
        occ_model = nxt;
        @(posedge clk);
        #1;
        drive_head();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 48'(stim_q.size() + exp_q.size()), 48'd0);
    endtask

    task automatic a_run(input logic m, input logic [15:0] d, input logic [15:0] ed, input logic ee);
        int lat;
        a_mode = m; a_data_in = d; a_in_valid = 1'b1;
        @(negedge clk);
        check("alt_in_ready", 48'(a_in_ready), 48'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("alt_latency", 48'(lat), 48'd3);
        check("alt_data_out", 48'(a_data_out), 48'(ed));
        check("alt_edge_error", 48'(a_edge_error), 48'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #(50000*PERIOD);
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        n_rst = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        a_clear = 1'b0; a_mode = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_data_in = '0;

        #(2*PERIOD + 2);
        check("rst_out_valid", 48'(out_valid), 48'd0);
        check("rst_data_out", data_out, 48'd0);
        check("rst_occupancy", 48'(occupancy), 48'd0);
        check("rst_alt_out_valid", 48'(a_out_valid), 48'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 48'(in_ready), 48'd1);
        @(posedge clk);
        #1;

        // Single beat into an empty pipe, with latency check
        add(1'b0, 48'h0000_8000_0001, 48'hC000_0000_0003, 1'b0, 1'b1);
        drive_head();
        drain(20);

        // Back-to-back stream with per-beat mode changes
        add(1'b0, 48'h0000_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
        add(1'b0, 48'h0000_0000_0000, 48'h0000_0000_0000, 1'b0, 1'b0);
        add(1'b0, 48'hABCD_8000_0001, 48'hC000_0000_0003, 1'b0, 1'b0);
        add(1'b1, 48'hC000_0000_0003, 48'h0000_8000_0001, 1'b0, 1'b0);
        add(1'b1, 48'h4000_0000_0003, 48'h0000_8000_0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            add(1'b0, {16'h0, x}, f_expand(x), 1'b0, 1'b0);
            add(1'b1, f_expand(x), {16'h0, x}, 1'b0, 1'b0);
        end
        drive_head();
        drain(100);

        // Backpressure: out_ready low for cycles 2..6
        saw_full = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            x = 32'h1111_1111 * i;
            add(1'b0, {16'h0, x}, f_expand(x), 1'b0, 1'b0);
        end
        drive_head();
        for (int c = 1; c <= 20; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            cycle();
        end
        out_ready = 1'b1;
        check("backpressure_full_seen", 48'(saw_full), 48'd1);
        drain(50);

        // clear with a full pipe and a beat on offer
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) add(1'b0, 48'(32'h0F0F_0000 + i), f_expand(32'h0F0F_0000 + i), 1'b0, 1'b0);
        drive_head();
        repeat (3) cycle();
        check("pre_clear_occupancy", 48'(occupancy), 48'd2);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        stim_q.delete();
        exp_q.delete();
        front_seen = 1'b0;
        drive_head();
        @(negedge clk);
        check("clear_occupancy", 48'(occupancy), 48'd0);
        check("clear_out_valid", 48'(out_valid), 48'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) cycle();
        add(1'b1, 48'hC000_0000_0003, 48'h0000_8000_0001, 1'b0, 1'b0);
        drive_head();
        drain(20);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) add(1'b0, 48'(32'hFFFF_FFFF), 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
        drive_head();
        repeat (3) cycle();
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_out_valid", 48'(out_valid), 48'd0);
        check("async_rst_data_out", data_out, 48'd0);
        check("async_rst_occupancy", 48'(occupancy), 48'd0);
        stim_q.delete();
        exp_q.delete();
        occ_model = 0;
        front_seen = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        add(1'b0, 48'h0000_8000_0001, 48'hC000_0000_0003, 1'b0, 1'b1);
        drive_head();
        drain(20);

        // Alternate parameters: GROUPS=4, GROUP_W=2, DEPTH=3
        a_run(1'b0, 16'h0081, 16'hC003, 1'b0);
        a_run(1'b1, 16'hC003, 16'h0081, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
